// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg -- shared definitions for the pipeline hazard controller.
//   FWD_REG / FWD_EXM / FWD_MWB : ALU operand-select encodings
//   state_e                     : hazard FSM states (RUN, LDSTALL, FLUSH)
//   slot_t                      : one scoreboard slot {valid, rd, regwrite, is_load}
//   slot_bubble()               : an invalid (NOP) scoreboard slot
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_EXM = 2'b01;  // operand from EX/MEM ALU result
    localparam logic [1:0] FWD_MWB = 2'b10;  // operand from MEM/WB result

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_FLUSH   = 2'b10
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } slot_t;

    function automatic slot_t slot_bubble();
        slot_t s;
        s.valid    = 1'b0;
        s.rd       = 5'd0;
        s.regwrite = 1'b0;
        s.is_load  = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if -- ID-stage / branch inputs and hazard-control outputs of
// pipe_ctrl grouped into one bundle.
//   master : drives the ID fields and br_taken, observes the controls
//   slave  : the controller itself
//   SCNT_W : width of stall_cnt
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int SCNT_W = 16
);
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [4:0]        id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              br_taken;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              flush_if;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [SCNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regwrite, id_is_load, br_taken,
        input  stall_if, stall_id, bubble_ex, flush_if,
               fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regwrite, id_is_load, br_taken,
        output stall_if, stall_id, bubble_ex, flush_if,
               fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_match.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_match -- decides whether one scoreboard slot produces the value
// one ID source operand needs.
//   slot_valid_i, slot_rd_i, slot_regwrite_i : slot contents
//   src_i, src_used_i                        : ID source register and read flag
//   match_o                                  : slot result is needed by source
// r0 never matches: it is hardwired to zero and writes to it are discarded.
// -----------------------------------------------------------------------------
module pipe_ctrl_match (
    input  logic       slot_valid_i,
    input  logic [4:0] slot_rd_i,
    input  logic       slot_regwrite_i,
    input  logic [4:0] src_i,
    input  logic       src_used_i,
    output logic       match_o
);
    assign match_o = slot_valid_i & slot_regwrite_i & src_used_i &
                     (slot_rd_i != 5'd0) & (slot_rd_i == src_i);
endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard controller for a 5-stage pipeline: tracks EX/MEM/WB
// destinations, raises load-use stalls, squashes on taken branches, selects
// ALU operand forwarding and counts lost cycles.
//   clk, rst  : clock, asynchronous active-high reset
//   ctrl_if   : pipe_ctrl_if.slave (ID fields, br_taken in; stall_if,
//               stall_id, bubble_ex, flush_if, fwd_a, fwd_b, stall_cnt out)
//   SCNT_W    : stall_cnt width (saturating)
// Build option PIPE_CTRL_FORWARD_EN: when defined, operands are forwarded
// from EX/MEM and MEM/WB and only a load directly ahead costs one stall cycle.
// When undefined, fwd_* stay 00 and ID waits while EX or MEM still owes a
// source (WB is written before the register-file read).
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int SCNT_W = 16
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave ctrl_if
);
    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

`ifdef PIPE_CTRL_FORWARD_EN
    localparam state_e STALL_NEXT = ST_LDSTALL;
`else
    localparam state_e STALL_NEXT = ST_RUN;
`endif

    slot_t             sb_q [3];
    slot_t             ex_d;
    state_e            state_q, state_d;
    logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [SCNT_W-1:0] cnt_q, cnt_d;
    logic              m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
    logic              hazard_s, stall_s, flush_s, issue_s;

    pipe_ctrl_match u_m_ex_rs (.slot_valid_i(sb_q[SB_EX].valid), .slot_rd_i(sb_q[SB_EX].rd),
        .slot_regwrite_i(sb_q[SB_EX].regwrite), .src_i(ctrl_if.id_rs),
        .src_used_i(ctrl_if.id_uses_rs), .match_o(m_ex_rs));
    pipe_ctrl_match u_m_ex_rt (.slot_valid_i(sb_q[SB_EX].valid), .slot_rd_i(sb_q[SB_EX].rd),
        .slot_regwrite_i(sb_q[SB_EX].regwrite), .src_i(ctrl_if.id_rt),
        .src_used_i(ctrl_if.id_uses_rt), .match_o(m_ex_rt));
    pipe_ctrl_match u_m_mem_rs (.slot_valid_i(sb_q[SB_MEM].valid), .slot_rd_i(sb_q[SB_MEM].rd),
        .slot_regwrite_i(sb_q[SB_MEM].regwrite), .src_i(ctrl_if.id_rs),
        .src_used_i(ctrl_if.id_uses_rs), .match_o(m_mem_rs));
    pipe_ctrl_match u_m_mem_rt (.slot_valid_i(sb_q[SB_MEM].valid), .slot_rd_i(sb_q[SB_MEM].rd),
        .slot_regwrite_i(sb_q[SB_MEM].regwrite), .src_i(ctrl_if.id_rt),
        .src_used_i(ctrl_if.id_uses_rt), .match_o(m_mem_rt));

    // Hazard detection: which ID reads cannot be satisfied this cycle.
    always_comb begin
`ifdef PIPE_CTRL_FORWARD_EN
        hazard_s = ctrl_if.id_valid & sb_q[SB_EX].is_load & (m_ex_rs | m_ex_rt);
`else
        hazard_s = ctrl_if.id_valid & (m_ex_rs | m_ex_rt | m_mem_rs | m_mem_rt);
`endif
    end

    // FSM next state and stall/flush decisions; a taken branch overrides any stall.
    always_comb begin
        state_d = state_q;
        stall_s = 1'b0;
        flush_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ctrl_if.br_taken) begin
                    flush_s = 1'b1;
                    state_d = ST_FLUSH;
                end else if (hazard_s) begin
                    stall_s = 1'b1;
                    state_d = STALL_NEXT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LDSTALL: begin
                // The load has moved to MEM; the consumer can now issue.
                if (ctrl_if.br_taken) begin
                    flush_s = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Second flush cycle; a new taken branch restarts the pair.
                flush_s = 1'b1;
                if (ctrl_if.br_taken) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // EX slot load, operand-select and counter next values.
    always_comb begin
        issue_s = ctrl_if.id_valid & ~stall_s & ~flush_s;
        ex_d    = slot_bubble();
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (issue_s) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = ctrl_if.id_rd;
            ex_d.regwrite = ctrl_if.id_regwrite;
            ex_d.is_load  = ctrl_if.id_is_load;
`ifdef PIPE_CTRL_FORWARD_EN
            // Youngest producer wins when both EX and MEM match.
            fwd_a_d = m_ex_rs ? FWD_EXM : (m_mem_rs ? FWD_MWB : FWD_REG);
            fwd_b_d = m_ex_rt ? FWD_EXM : (m_mem_rt ? FWD_MWB : FWD_REG);
`endif
        end else begin
            ex_d = slot_bubble();
        end
        if ((stall_s | flush_s) && (cnt_q != {SCNT_W{1'b1}})) begin
            cnt_d = cnt_q + SCNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, scoreboard and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            sb_q[SB_EX]  <= slot_bubble();
            sb_q[SB_MEM] <= slot_bubble();
            sb_q[SB_WB]  <= slot_bubble();
            fwd_a_q      <= FWD_REG;
            fwd_b_q      <= FWD_REG;
            cnt_q        <= {SCNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            sb_q[SB_EX]  <= ex_d;
            sb_q[SB_MEM] <= sb_q[SB_EX];
            sb_q[SB_WB]  <= sb_q[SB_MEM];
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ctrl_if.stall_if  = stall_s;
    assign ctrl_if.stall_id  = stall_s;
    assign ctrl_if.bubble_ex = stall_s | flush_s;
    assign ctrl_if.flush_if  = flush_s;
    assign ctrl_if.fwd_a     = fwd_a_q;
    assign ctrl_if.fwd_b     = fwd_b_q;
    assign ctrl_if.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- table-driven bench for pipe_ctrl. Each table row is one
// cycle of ID/branch/reset inputs with the outputs expected in that cycle;
// rows are queued as they are driven and popped for comparison before the
// next rising edge. A hand-written sequence then exercises reset asserted
// asynchronously in the middle of a flush. stall_cnt is narrowed to 3 bits
// so saturation is reached within a few cycles. Expectations follow the
// PIPE_CTRL_FORWARD_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
    localparam int SCNT_W = 3;
`ifdef PIPE_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.SCNT_W(SCNT_W)) bus ();
    pipe_ctrl #(.SCNT_W(SCNT_W)) dut (.clk(clk), .rst(rst), .ctrl_if(bus.slave));

    typedef struct {
        logic r, v;
        logic [4:0] rs, rt;
        logic urs, urt;
        logic [4:0] rd;
        logic rw, ld, br;
        logic st, bub, fl;
        logic [1:0] fa, fb;
        logic [SCNT_W-1:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, v, input logic [4:0] rs, rt,
                                input logic urs, urt, input logic [4:0] rd,
                                input logic rw, ld, br, st, bub, fl,
                                input logic [1:0] fa, fb, input int cnt);
        vec_t t;
        t.r = r; t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
        t.rd = rd; t.rw = rw; t.ld = ld; t.br = br;
        t.st = st; t.bub = bub; t.fl = fl; t.fa = fa; t.fb = fb;
        t.cnt = SCNT_W'(cnt);
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst             = t.r;
        bus.id_valid    = t.v;
        bus.id_rs       = t.rs;
        bus.id_rt       = t.rt;
        bus.id_uses_rs  = t.urs;
        bus.id_uses_rt  = t.urt;
        bus.id_rd       = t.rd;
        bus.id_regwrite = t.rw;
        bus.id_is_load  = t.ld;
        bus.br_taken    = t.br;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t e;
        drive(mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0));

        // r v rs rt urs urt rd rw ld br | st bub fl fa fb cnt
        tbl.push_back(mk(1,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd0,2'd0,0));  // reset state
`ifdef PIPE_CTRL_FORWARD_EN
        tbl.push_back(mk(0,1, 1, 2,1,1, 3,1,0,0, 0,0,0,2'd0,2'd0,0));  // add r3
        tbl.push_back(mk(0,1, 3, 4,1,1, 6,1,0,0, 0,0,0,2'd0,2'd0,0));  // reads r3: no stall
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd1,2'd0,0));  // fwd_a=01
        tbl.push_back(mk(0,1, 1, 0,1,0, 5,1,1,0, 0,0,0,2'd0,2'd0,0));  // lw r5
        tbl.push_back(mk(0,1, 1, 5,1,1, 9,1,0,0, 1,1,0,2'd0,2'd0,0));  // load-use stall
        tbl.push_back(mk(0,1, 1, 5,1,1, 9,1,0,0, 0,0,0,2'd0,2'd0,1));  // issues
        tbl.push_back(mk(0,1, 1, 2,1,1,10,1,0,0, 0,0,0,2'd0,2'd2,1));  // fwd_b=10
        tbl.push_back(mk(0,1, 1, 2,1,1,10,1,0,0, 0,0,0,2'd0,2'd0,1));  // second r10 writer
        tbl.push_back(mk(0,1,10, 0,1,0,11,1,0,0, 0,0,0,2'd0,2'd0,1));  // EX and MEM both match
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd1,2'd0,1));  // EX wins
`else
        tbl.push_back(mk(0,1, 1, 2,1,1, 7,1,0,0, 0,0,0,2'd0,2'd0,0));  // add r7
        tbl.push_back(mk(0,1, 7, 0,1,0, 8,1,0,0, 1,1,0,2'd0,2'd0,0));  // stall on EX
        tbl.push_back(mk(0,1, 7, 0,1,0, 8,1,0,0, 1,1,0,2'd0,2'd0,1));  // stall on MEM
        tbl.push_back(mk(0,1, 7, 0,1,0, 8,1,0,0, 0,0,0,2'd0,2'd0,2));  // WB only: issues
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd0,2'd0,2));
`endif
        tbl.push_back(mk(1,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd0,2'd0,0));  // reset
        tbl.push_back(mk(0,1, 1, 2,1,1, 0,1,0,0, 0,0,0,2'd0,2'd0,0));  // writes r0
        tbl.push_back(mk(0,1, 0, 0,1,1, 9,1,0,0, 0,0,0,2'd0,2'd0,0));  // reads r0
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd0,2'd0,0));  // fwd=00
        tbl.push_back(mk(0,1, 1, 2,1,1, 5,1,1,0, 0,0,0,2'd0,2'd0,0));  // lw r5
        tbl.push_back(mk(0,1, 1, 5,1,1,12,1,0,1, 0,1,1,2'd0,2'd0,0));  // hazard + branch
        tbl.push_back(mk(0,1, 1, 5,1,1,12,1,0,0, 0,1,1,2'd0,2'd0,1));  // second flush
        tbl.push_back(mk(0,1, 1, 5,1,1,12,1,0,0, 0,0,0,2'd0,2'd0,2));  // stall discarded
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd0,2'd0,2));
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,1, 0,1,1,2'd0,2'd0,2));  // branch
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,1, 0,1,1,2'd0,2'd0,3));  // branch in FLUSH
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,1,1,2'd0,2'd0,4));  // restarted pair
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd0,2'd0,5));
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,1, 0,1,1,2'd0,2'd0,5));
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,1, 0,1,1,2'd0,2'd0,6));
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,1, 0,1,1,2'd0,2'd0,7));
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,1,1,2'd0,2'd0,7));  // saturated
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd0,2'd0,7));
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,1, 0,1,1,2'd0,2'd0,7));  // branch
        tbl.push_back(mk(1,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd0,2'd0,0));  // rst in FLUSH
        tbl.push_back(mk(0,1, 1, 2,1,1, 3,1,0,0, 0,0,0,2'd0,2'd0,0));  // add r3 issues
        tbl.push_back(mk(0,1, 3, 0,1,0, 4,1,0,0, !FWD,!FWD,0,2'd0,2'd0,0));
        tbl.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,{1'b0,FWD},2'd0,FWD ? 0 : 1));

        repeat (2) @(negedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            #2;
            e = exp_q.pop_front();
            chk("stall_if",  i, 32'(bus.stall_if),  32'(e.st));
            chk("stall_id",  i, 32'(bus.stall_id),  32'(e.st));
            chk("bubble_ex", i, 32'(bus.bubble_ex), 32'(e.bub));
            chk("flush_if",  i, 32'(bus.flush_if),  32'(e.fl));
            chk("fwd_a",     i, 32'(bus.fwd_a),     32'(e.fa));
            chk("fwd_b",     i, 32'(bus.fwd_b),     32'(e.fb));
            chk("stall_cnt", i, 32'(bus.stall_cnt), 32'(e.cnt));
        end

        // Reset asserted mid-cycle during a flush must clear outputs at once.
        @(negedge clk);
        drive(mk(0,0, 0, 0,0,0, 0,0,0,1, 0,0,0,2'd0,2'd0,0));
        @(posedge clk);
        #1;
        chk("flush_pre_rst", 900, 32'(bus.flush_if), 32'd1);
        bus.br_taken = 1'b0;
        rst = 1'b1;
        #1;
        chk("flush_async_rst",  901, 32'(bus.flush_if),  32'd0);
        chk("bubble_async_rst", 902, 32'(bus.bubble_ex), 32'd0);
        chk("cnt_async_rst",    903, 32'(bus.stall_cnt), 32'd0);
        @(negedge clk);
        drive(mk(0,1, 1, 2,1,1, 3,1,0,0, 0,0,0,2'd0,2'd0,0));
        #2;
        chk("issue_after_rst_stall", 904, 32'(bus.stall_id),  32'd0);
        chk("issue_after_rst_flush", 905, 32'(bus.flush_if),  32'd0);
        @(negedge clk);
        drive(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,2'd0,2'd0,0));
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
